// File: rtl/tweakey_loader.sv
// tweakey_loader: loads the hash key, registers tweaks, captures tweakeys.
// Optional: TWEAKEY_KEY_ZEROIZE_EN adds the key_zeroize input.
module tweakey_loader #(
  parameter int WORD_W    = 32,
  parameter int KEY_LEN   = 254,
  parameter int TWEAK_LEN = 64,
  parameter int TK_LEN    = 128,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef TWEAKEY_KEY_ZEROIZE_EN
  input  logic                 key_zeroize,
`endif
  input  logic                 key_wr_valid,
  input  logic [WORD_W-1:0]    key_wr_data,
  output logic                 key_wr_ready,
  output logic                 key_loaded,
  input  logic                 tweak_valid,
  input  logic [TWEAK_LEN-1:0] tweak_data,
  output logic                 tweak_ready,
  output logic [TWEAK_LEN-1:0] hash_tweak,
  output logic [KEY_LEN-1:0]   hash_key,
  input  logic [TK_LEN-1:0]    hash_tweakey,
  output logic                 tk_valid,
  input  logic                 tk_ready,
  output logic [TK_LEN-1:0]    tk_data
);

  typedef enum logic [2:0] {
    NOKEY,
    LOAD,
    READY,
    EVAL,
    OUT
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             wcnt_q, wcnt_d;
  logic [3:0]             scnt_q, scnt_d;
  logic [KEY_LEN-1:0]     key_q, key_d;
  logic [TWEAK_LEN-1:0]   twk_q, twk_d;
  logic [TK_LEN-1:0]      tk_q, tk_d;
  logic                   loaded_q, loaded_d;
  logic                   tkv_q, tkv_d;

  logic                   key_acc;
  logic                   twk_acc;
  logic [2:0]             wr_idx;
  logic [KEY_LEN-1:0]     key_wr;

  // Handshake readies come straight from state; key write beats tweak.
  always_comb begin
    key_wr_ready = (state_q == NOKEY) ||
                   (state_q == LOAD)  ||
                   (state_q == READY);
    tweak_ready  = (state_q == READY) && !key_wr_valid;
    key_acc      = key_wr_valid && key_wr_ready;
    twk_acc      = tweak_valid && tweak_ready;
  end

  // Merge the incoming word into its slot; bits past KEY_LEN drop off.
  always_comb begin
    wr_idx = (state_q == LOAD) ? wcnt_q : 3'd0;
    key_wr = key_q;
    for (int b = 0; b < KEY_LEN; b++) begin
      if (b / WORD_W == int'(wr_idx)) begin
        key_wr[b] = key_wr_data[b % WORD_W];
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    scnt_d   = scnt_q;
    key_d    = key_q;
    twk_d    = twk_q;
    tk_d     = tk_q;
    loaded_d = loaded_q;
    tkv_d    = tkv_q;
    unique case (state_q)
      NOKEY: begin
        if (key_acc) begin
          key_d    = key_wr;
          wcnt_d   = 3'd1;
          loaded_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (key_acc) begin
          key_d  = key_wr;
          wcnt_d = wcnt_q + 3'd1;
          if (wcnt_q == 3'd7) begin
            loaded_d = 1'b1;
            state_d  = READY;
          end
        end
      end
      READY: begin
        if (key_acc) begin
          key_d    = key_wr;
          wcnt_d   = 3'd1;
          loaded_d = 1'b0;
          state_d  = LOAD;
        end else if (twk_acc) begin
          twk_d   = tweak_data;
          scnt_d  = 4'(SETTLE - 1);
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (scnt_q == 4'd0) begin
          tk_d    = hash_tweakey;
          tkv_d   = 1'b1;
          state_d = OUT;
        end else begin
          scnt_d = scnt_q - 4'd1;
        end
      end
      OUT: begin
        if (tk_ready) begin
          tkv_d   = 1'b0;
          state_d = READY;
        end
      end
      default: state_d = NOKEY;
    endcase
`ifdef TWEAKEY_KEY_ZEROIZE_EN
    if (key_zeroize) begin
      state_d  = NOKEY;
      wcnt_d   = 3'd0;
      scnt_d   = 4'd0;
      key_d    = '0;
      twk_d    = '0;
      tk_d     = '0;
      loaded_d = 1'b0;
      tkv_d    = 1'b0;
    end
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= NOKEY;
      wcnt_q   <= 3'd0;
      scnt_q   <= 4'd0;
      key_q    <= '0;
      twk_q    <= '0;
      tk_q     <= '0;
      loaded_q <= 1'b0;
      tkv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      scnt_q   <= scnt_d;
      key_q    <= key_d;
      twk_q    <= twk_d;
      tk_q     <= tk_d;
      loaded_q <= loaded_d;
      tkv_q    <= tkv_d;
    end
  end

  assign hash_key   = key_q;
  assign hash_tweak = twk_q;
  assign tk_data    = tk_q;
  assign tk_valid   = tkv_q;
  assign key_loaded = loaded_q;

endmodule

// File: doc/tweakey_loader.md
# tweakey_loader

Upstream front end for the combinational tweakey hash. It loads the 254-bit hash key over a 32-bit write port and accepts 64-bit tweaks through a valid/ready handshake. It drives the registered key and tweak into the hash, waits a programmable settle interval, then captures the 128-bit tweakey into an output register. The captured tweakey is presented to the cipher core with its own valid/ready handshake.

## Interface
- `WORD_W`, 32: key write word width (fixed; other values are unsupported).
- `KEY_LEN`, 254: hash key length (2 × 127).
- `TWEAK_LEN`, 64: tweak width.
- `TK_LEN`, 128: tweakey width.
- `SETTLE`, 2: cycles allowed for the combinational hash to settle; legal range 1–15.

Ports:
- `clk`  in  1  the single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `key_wr_valid`  in  1  key word present.
- `key_wr_data`  in  32  key word.
- `key_wr_ready`  out  1  key word accepted when `valid` and `ready` are both high.
- `key_loaded`  out  1  all 8 key words have been written since the last reset or reload start.
- `tweak_valid`  in  1  tweak present.
- `tweak_data`  in  64  tweak value.
- `tweak_ready`  out  1  tweak accepted when `valid` and `ready` are both high.
- `hash_tweak`  out  64  registered tweak driven to the hash.
- `hash_key`  out  254  registered key driven to the hash.
- `hash_tweakey`  in  128  combinational hash result.
- `tk_valid`  out  1  `tk_data` holds a captured tweakey.
- `tk_ready`  in  1  consumer accepts `tk_data`.
- `tk_data`  out  128  captured tweakey.
- `key_zeroize`  in  1  present only with `TWEAKEY_KEY_ZEROIZE_EN`.

## Operation
- States:
  - NOKEY: the reset state.
  - LOAD: 1–7 key words received.
  - READY: key complete, idle.
  - EVAL: the hash is settling.
  - OUT: `tk_valid` is high.
- Key word n (0–7) is written to key register bits [32n+31:32n].
  - Bits [255:254] of the assembled 256 bits are discarded.
  - A 3-bit word counter tracks the next word index.
- `key_wr_ready` is 1 in NOKEY, LOAD and READY, and 0 in EVAL and OUT.
- Transitions on a key word accepted:
  - From NOKEY or READY: go to LOAD, set counter to 1, drop `key_loaded`.
  - In LOAD: increment the counter. On word 7, go to READY and set `key_loaded` to 1.
- `tweak_ready` = 1 only in READY.
- In READY, a simultaneous `key_wr_valid` and `tweak_valid`: the key write wins and `tweak_ready` is 0 that cycle. `tweak_ready` is therefore combinationally gated by `!key_wr_valid`.
- Tweak accepted in READY:
  - `hash_tweak` ← `tweak_data`.
  - Go to EVAL with settle counter ← SETTLE-1.
- In EVAL:
  - If the counter is 0: `tk_data` ← `hash_tweakey`, go to OUT.
  - Otherwise decrement the counter.
- In OUT, `tk_valid` = 1 and `tk_data` is held stable. On `tk_ready`, go to READY.
- `hash_key` always reflects the key register, including mid-load partial values. The consumer ignores `hash_tweakey` outside EVAL.

## Timing
- Reset values:
  - State NOKEY.
  - `key_loaded`=0, `tk_valid`=0, `tk_data`=0, `hash_tweak`=0, `hash_key`=0.
  - Word and settle counters = 0.
  - `key_wr_ready`=1, `tweak_ready`=0.
- Latency: tweak accepted at edge E → `tk_valid` high after edge E+SETTLE.
- Minimum tweak-to-tweak interval: SETTLE+2 cycles when `tk_ready` is held high.
  - One cycle is spent in OUT.
  - One cycle is spent in READY for re-acceptance; there is no bypass.
- Key load: 8 accepted words, so a minimum of 8 cycles. `key_loaded` rises after the edge that accepts word 7.
- Reset mid-LOAD or mid-EVAL: the next cycle is in NOKEY with all registers at reset values. A pending tweak is dropped and `tk_valid` is never raised for it.
- Reset in OUT: `tk_valid` falls after the reset edge and the tweakey is lost.
- Back-pressure: `tk_ready` low holds OUT indefinitely. `tk_data` must not change while `tk_valid` is high.

## Configuration
- `TWEAKEY_KEY_ZEROIZE_EN` defined:
  - Adds the `key_zeroize` input.
  - When sampled high in any state, at the next edge the key register, `hash_key`, `hash_tweak` and `tk_data` are cleared to 0, `key_loaded` and `tk_valid` go to 0, and the state goes to NOKEY.
  - Priority: zeroize is below `rst_n` and above every handshake.
- Not defined: the port is absent, and the key can only be replaced by a full 8-word reload from READY.

## Test plan
- Reset, then write words 0x00000001…0x00000008 with `valid` held → `key_loaded` rises after word 7. `hash_key[31:0]`=1 and `hash_key[253:224]`=8 & 0x3FFFFFFF.
- Key loaded, SETTLE=2, tweak 0x0123456789ABCDEF, model hash `hash_tweakey`={tweak,~tweak} → `tk_valid` after edge E+2 with `tk_data`={0x0123456789ABCDEF,0xFEDCBA9876543210}.
- `tk_ready` held low for 10 cycles in OUT → `tk_valid`=1 and `tk_data` constant. `tweak_ready`=0 and `key_wr_ready`=0 throughout.
- In READY, assert `key_wr_valid` and `tweak_valid` together → key word accepted, `tweak_ready`=0, state LOAD, `key_loaded`=0.
- `rst_n` low for one cycle during EVAL → `tk_valid` never asserts, all outputs return to 0, `key_wr_ready`=1.
- With `TWEAKEY_KEY_ZEROIZE_EN`, pulse `key_zeroize` in OUT → next cycle `tk_valid`=0, `tk_data`=0, `hash_key`=0, `key_loaded`=0. A subsequent tweak is refused until 8 new key words are loaded.
